// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART echo design.
//   rx_state_t / tx_state_t : receiver / transmitter FSM states
//   FRAME_BITS              : start + 8 data + stop
//   DATA_BITS               : payload bits per frame
//   baud_div()              : clocks per bit, rounded to nearest
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    function automatic int baud_div(input int clock_hz, input int baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, byte + valid strobe.
// Ports:
//   i_clk   in   system clock, rising edge
//   i_rst   in   asynchronous active-high reset
//   i_rx    in   serial line, idle high
//   o_data  out  last received byte (valid while o_valid is high)
//   o_valid out  one-cycle strobe, the cycle after a good stop bit is sampled
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);
    // Counting from DIV-1 down to 0 spans exactly DIV clocks between samples.
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

    rx_state_t     r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          w_rx;

    assign w_rx    = r_sync2;
    assign o_data  = r_shift;
    assign o_valid = r_valid;

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the pre-edge values, exactly like the hardware it describes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= RX_IDLE;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    // Arm only after seeing a clean high, so a stuck-low line
                    // (or a trailing framing-error low) never starts a frame.
                    if (!r_armed) begin
                        if (w_rx == 1'b1) r_armed <= 1'b1;
                    end else if (w_rx == 1'b0) begin
                        r_cnt   <= HALF;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (w_rx == 1'b0) begin
                        r_cnt     <= FULL;
                        r_bit_cnt <= '0;
                        r_state   <= RX_DATA;
                    end else begin
                        r_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_cnt     <= FULL;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == LAST) r_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        if (w_rx == 1'b1) r_valid <= 1'b1;
                        r_armed <= 1'b0;
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 transmitter with a ready/valid byte input. Each bit lasts DIV clocks.
// Ports:
//   i_clk   in   system clock, rising edge
//   i_rst   in   asynchronous active-high reset (line forced high)
//   i_data  in   byte to send
//   i_valid in   byte available
//   o_ready out  byte accepted this cycle when i_valid is also high
//   o_tx    out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [2:0]    LAST = 3'(DATA_BITS - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_tx;

    // Accepting on the last stop-bit clock lets the next start bit follow
    // with no idle gap between queued frames.
    assign o_ready = (r_state == TX_IDLE) || ((r_state == TX_STOP) && (r_cnt == '0));
    assign o_tx    = r_tx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_cnt   <= FULL;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_cnt     <= FULL;
                        r_bit_cnt <= '0;
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_bit_cnt == LAST) begin
                        r_tx    <= 1'b1;
                        r_cnt   <= FULL;
                        r_state <= TX_STOP;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_cnt     <= FULL;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (i_valid) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_cnt   <= FULL;
                        r_state <= TX_START;
                    end else begin
                        r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_top.sv
// -----------------------------------------------------------------------------
// uart_echo_top
// UART 8N1 loopback: bytes received on io_rx are queued in a small FIFO and
// retransmitted unchanged on io_tx at the same baud rate.
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   io_rx  in   UART receive line, idle high
//   io_tx  out  UART transmit line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_echo_top
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic io_rx,
    output logic io_tx
);

    localparam int DIV = baud_div(CLOCK_HZ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);

    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_echo_top: DIV must be at least 4");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_echo_top: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_tx_ready;
    logic       w_tx_line;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    uart_rx #(.DIV(DIV)) u_rx (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_rx    (io_rx),
        .o_data  (w_rx_data),
        .o_valid (w_rx_valid)
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = w_tx_ready && !w_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_push  = w_rx_valid && (!w_full || w_pop);

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_rx_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    uart_tx #(.DIV(DIV)) u_tx (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_data  (r_mem[r_rptr[AW-1:0]]),
        .i_valid (!w_empty),
        .o_ready (w_tx_ready),
        .o_tx    (w_tx_line)
    );

    assign io_tx = w_tx_line;

endmodule

// File: tb/tb_uart_echo_top.sv
module tb_uart_echo_top;

    localparam int CLOCK_HZ   = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int DIV        = 10;
    localparam int FRAME_CLKS = 10 * DIV;
    localparam int NVEC       = 9;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         idle_after;
        bit         echo;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         rx_start;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic io_rx = 1'b1;
    logic io_tx;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    exp_t sb[$];
    int   tx_starts[$];

    uart_echo_top #(
        .CLOCK_HZ   (CLOCK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_rx (io_rx),
        .io_tx (io_tx)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Drives one 8N1 frame; must be called at posedge+1 and returns at posedge+1.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int idle_after, input bit expect_echo);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        if (expect_echo) sb.push_back('{d, cyc});
        for (int b = 0; b < 10; b++) begin
            io_rx = bits[b];
            repeat (DIV) @(posedge clock);
            #1;
        end
        io_rx = 1'b1;
        if (idle_after > 0) begin
            repeat (idle_after) @(posedge clock);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        check({name, " drain within budget"}, 32'(n < 3000), 32'd1);
    endtask

    // Scoreboard monitor: every falling edge of io_tx starts a frame that is
    // compared clock by clock against the next expected byte.
    initial begin : monitor
        logic       prev;
        exp_t       e;
        logic [9:0] exp_bits;
        logic [7:0] got;
        int         bad;
        int         lat;
        bit         have;
        prev = 1'b1;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && prev === 1'b1 && io_tx === 1'b0) begin
                mon_busy = 1'b1;
                frames_seen++;
                tx_starts.push_back(cyc);
                have = (sb.size() > 0);
                if (have) begin
                    e = sb.pop_front();
                end else begin
                    e.data     = 8'h00;
                    e.rx_start = cyc;
                    check("frame on io_tx was expected", 32'd0, 32'd1);
                end
                exp_bits = {1'b1, e.data, 1'b0};
                bad = 0;
                got = 8'h00;
                for (int k = 0; k < FRAME_CLKS; k++) begin
                    if (k > 0) @(negedge clock);
                    if (io_tx !== exp_bits[k / DIV]) bad++;
                    if ((k % DIV) == (DIV / 2) && (k / DIV) >= 1 && (k / DIV) <= 8)
                        got[(k / DIV) - 1] = io_tx;
                end
                if (have) begin
                    lat = tx_starts[tx_starts.size() - 1] - e.rx_start;
                    check($sformatf("echo byte #%0d", frames_seen), 32'(got), 32'(e.data));
                    check($sformatf("bit timing #%0d (bad clocks)", frames_seen), 32'(bad), 32'd0);
                    check($sformatf("latency #%0d in range (lat=%0d)", frames_seen, lat),
                          32'(lat >= 9 * DIV && lat <= 10 * DIV + 4), 32'd1);
                end
                prev = io_tx;
                mon_busy = 1'b0;
            end else begin
                prev = io_tx;
            end
        end
    end

    initial begin : main
        vec_t vecs[NVEC];
        int   lows;
        int   n;

        // 0x55 alone; 0xA5 with a bad stop then 0x3C; six back-to-back frames.
        vecs[0] = '{8'h55, 1'b1, 200, 1'b1};
        vecs[1] = '{8'hA5, 1'b0, 30,  1'b0};
        vecs[2] = '{8'h3C, 1'b1, 200, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 0,   1'b1};
        vecs[4] = '{8'hFF, 1'b1, 0,   1'b1};
        vecs[5] = '{8'h01, 1'b1, 0,   1'b1};
        vecs[6] = '{8'h80, 1'b1, 0,   1'b1};
        vecs[7] = '{8'h5A, 1'b1, 0,   1'b1};
        vecs[8] = '{8'hC3, 1'b1, 200, 1'b1};

        // Reset and idle.
        #1 reset = 1'b1;
        #1 check("io_tx during reset", 32'(io_tx), 32'd1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (io_tx !== 1'b1) lows++;
        end
        check("idle io_tx low clocks", 32'(lows), 32'd0);

        // Short low pulse on io_rx must be rejected.
        @(posedge clock);
        #1 io_rx = 1'b0;
        repeat (3) @(posedge clock);
        #1 io_rx = 1'b1;
        repeat (200) @(posedge clock);
        #1;
        check("frames after glitch", 32'(frames_seen), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < NVEC; i++)
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].idle_after, vecs[i].echo);
        drain("table");
        repeat (20) @(posedge clock);
        check("frames echoed", 32'(frames_seen), 32'd8);
        if (tx_starts.size() == 8) begin
            for (int j = 3; j < 8; j++)
                check($sformatf("back-to-back gap %0d", j), 32'(tx_starts[j] - tx_starts[j-1]),
                      32'(FRAME_CLKS));
        end

        // Reset while 0x0F is in its data bits.
        mon_en = 1'b0;
        @(posedge clock);
        #1;
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        n = 0;
        while (io_tx !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("tx start for 0x0F seen", 32'(n < 400), 32'd1);
        repeat (55) @(negedge clock);
        check("io_tx low in data bit d4", 32'(io_tx), 32'd0);
        #2 reset = 1'b1;
        #1 check("io_tx high in reset clock", 32'(io_tx), 32'd1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (io_tx !== 1'b1) lows++;
        end
        check("no resume after reset (low clocks)", 32'(lows), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
